uart_transmitter: RTL and testbench

Serial transmit half of the UART peripheral on the APB bus. It accepts one byte per handshake from the APB interface and shifts it out on `txd` as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, one stop bit. Timing comes from a baud counter derived from the board clock. It pairs with the existing receiver to make the UART full duplex.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_transmitter.sv | 126 ++++++++++++
 tb/tb_uart_transmitter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_t;

    // Board clocks per serial bit, truncated; callers must keep the result >= 2.
    function automatic int calc_clks_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Free-run while not cleared, wrapping to 0 on every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: start bit, 8 data bits LSB first, optional parity, one stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for tx_enable && tx_start
// START  | driving the start bit (0)
// DATA   | driving shift[0], one data bit per bit period
// PARITY | driving the latched parity bit
// STOP   | driving the stop bit (1); done pulses when it ends
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_enable,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_RATE, BAUD_RATE);

    localparam logic [2:0] S_IDLE   = UART_IDLE;
    localparam logic [2:0] S_START  = UART_START;
    localparam logic [2:0] S_DATA   = UART_DATA;
    localparam logic [2:0] S_PARITY = UART_PARITY;
    localparam logic [2:0] S_STOP   = UART_STOP;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_idx;
    logic                 par_en;
    logic                 par_bit;
    logic                 bit_tick;

    // The baud counter is held at 0 in IDLE, so the accept edge starts a fresh bit period.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_IDLE),
        .bit_tick(bit_tick)
    );

    // Frame sequencer; every output is registered so txd moves one cycle after its decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            txd     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_enable && tx_start) begin
                        shift   <= tx_data_in;
                        par_en  <= parity_en;
                        // Parity is fixed at accept so later input changes cannot disturb it.
                        par_bit <= (^tx_data_in) ^ parity_odd;
                        bit_idx <= '0;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        txd   <= shift[0];
                        shift <= {1'b0, shift[DATA_BITS-1:1]};
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            if (par_en) begin
                                txd   <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[0];
                            shift   <= {1'b0, shift[DATA_BITS-1:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        txd   <= 1'b1;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 16 clocks per bit.
module tb_uart_transmitter;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       tx_enable;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       parity_en;
    logic       parity_odd;
    logic       txd;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       po;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    uart_transmitter #(
        .CLOCK_RATE(16),
        .BAUD_RATE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_enable (tx_enable),
        .tx_start  (tx_start),
        .tx_data_in(tx_data_in),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .txd       (txd),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request and record the frame it should produce; returns just after the accept edge.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic po, input logic hold);
        @(negedge clk);
        tx_data_in = d;
        parity_en  = pe;
        parity_odd = po;
        tx_enable  = 1'b1;
        tx_start   = 1'b1;
        exp_q.push_back('{data: d, pe: pe, po: po});
        @(posedge clk);
        #1;
        if (!hold) tx_start = 1'b0;
    endtask

    // Check the frame whose accept edge was the last posedge; act: 1 drop start, 2 drop enable, 3 pulse 0xFF.
    task automatic check_frame(input string name, input int act, input int act_cyc);
        frame_t f;
        logic   bits [0:10];
        int     n;
        int     busy_bad;
        int     done_bad;
        int     hold_bad;
        int     i;
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
            return;
        end
        f = exp_q.pop_front();
        n = f.pe ? 11 : 10;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = f.data[k];
        bits[9]  = (^f.data) ^ f.po;
        bits[10] = 1'b1;
        bits[n-1] = 1'b1;
        busy_bad = 0;
        done_bad = 0;
        for (int b = 0; b < n; b++) begin
            hold_bad = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                i = b * CPB + c;
                if (c == 0) chk($sformatf("%s_bit%0d_level", name, b), txd, bits[b]);
                if (txd !== bits[b]) hold_bad++;
                if (busy !== 1'b1) busy_bad++;
                if (done !== 1'b0) done_bad++;
                if (act == 1 && i == act_cyc) tx_start = 1'b0;
                if (act == 2 && i == act_cyc) tx_enable = 1'b0;
                if (act == 3 && i == act_cyc) begin
                    tx_data_in = 8'hFF;
                    tx_start   = 1'b1;
                end
                if (act == 3 && i == act_cyc + 1) tx_start = 1'b0;
            end
            chk($sformatf("%s_bit%0d_hold", name, b), hold_bad, 0);
        end
        chk({name, "_busy_len"}, busy_bad, 0);
        chk({name, "_done_early"}, done_bad, 0);
        @(negedge clk);
        chk({name, "_end_busy"}, busy, 0);
        chk({name, "_end_done"}, done, 1);
        chk({name, "_end_txd"}, txd, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        int bad;
        rst        = 1'b1;
        tx_enable  = 1'b0;
        tx_start   = 1'b0;
        tx_data_in = 8'h00;
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Reset held with toggling inputs.
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            tx_start   = 1'($urandom_range(0, 1));
            tx_enable  = 1'($urandom_range(0, 1));
            tx_data_in = 8'($urandom_range(0, 255));
            parity_en  = 1'($urandom_range(0, 1));
        end
        chk("reset_hold", bad, 0);
        @(negedge clk);
        rst      = 1'b0;
        tx_start = 1'b0;
        check_idle("post_reset_idle", 20);

        // Basic frame and parity variants.
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check_frame("a5", 0, 0);
        check_idle("idle_after_a5", 5);
        start_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check_frame("07_even", 0, 0);
        check_idle("idle_after_07e", 5);
        start_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check_frame("07_odd", 0, 0);
        check_idle("idle_after_07o", 5);
        start_frame(8'h00, 1'b1, 1'b0, 1'b0);
        check_frame("00_even", 0, 0);
        check_idle("idle_after_00e", 5);

        // Start pulse while busy is dropped, and the in-flight data is unaffected.
        start_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_frame("3c", 3, 40);
        check_idle("ff_ignored", 40);

        // Held start gives back-to-back frames one cycle after done.
        start_frame(8'h81, 1'b0, 1'b0, 1'b1);
        check_frame("81_first", 0, 0);
        exp_q.push_back('{data: 8'h81, pe: 1'b0, po: 1'b0});
        check_frame("81_second", 1, 100);
        check_idle("idle_after_81", 40);

        // Reset during data bit 3 abandons the frame immediately.
        start_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (70) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("idle_after_mid_rst", 20);
        start_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        check_frame("c3", 0, 0);
        check_idle("idle_after_c3", 5);

        // Enable gating.
        @(negedge clk);
        tx_enable = 1'b0;
        tx_start  = 1'b1;
        check_idle("enable_gated", 50);
        tx_start = 1'b0;
        start_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_frame("5a_en_drop", 2, 20);
        check_idle("idle_after_5a", 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
